// File: rtl/wfm_capture_pkg.sv
// Shared types and constants for the waveform capture block: FSM states, record word layout, counter widths.
// No logic; pure declarations.
// Header word layout (CAPTURE_HEADER_EN): {bsum[17:0], timestamp[45:0]}.
package wfm_capture_pkg;

   localparam int TS_W   = 46;
   localparam int DROP_W = 16;
   localparam int SMP_W  = 14;
   localparam int BSUM_W = 18;
   localparam int WORD_W = 64;
   localparam int LINE_W = 60;
   localparam int FIFO_W = WORD_W + 2;

   // Sample word field offsets; bits 63:60 of a data word are zero padding.
   localparam int IN0_LSB = 0;
   localparam int IN1_LSB = 14;
   localparam int IN2_LSB = 28;
   localparam int IN3_LSB = 42;
   localparam int TOT_LSB = 56;

   typedef logic [0:0] state_t;
   localparam state_t ST_IDLE    = 1'b0;
   localparam state_t ST_CAPTURE = 1'b1;

   function automatic logic [LINE_W-1:0] pack_line(input logic [3:0] tot,
                                                   input logic [SMP_W-1:0] s0, s1, s2, s3);
      logic [LINE_W-1:0] line;
      line = '0;
      line[IN0_LSB +: SMP_W] = s0;
      line[IN1_LSB +: SMP_W] = s1;
      line[IN2_LSB +: SMP_W] = s2;
      line[IN3_LSB +: SMP_W] = s3;
      line[TOT_LSB +: 4]     = tot;
      return line;
   endfunction

endpackage

// File: rtl/capture_fifo.sv
// Show-ahead FIFO holding record words with their hdr/last flags; reports occupancy.
// Latency: a push into an empty FIFO is visible on pop_dat the next cycle.
// Backpressure: pop only on pop_vld & pop_rdy; pushes while full are discarded (writer checks count first).
module capture_fifo #(
   parameter int W     = 66,
   parameter int DEPTH = 256,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          push_vld,
   input  logic [W-1:0]  push_dat,
   output logic          pop_vld,
   input  logic          pop_rdy,
   output logic [W-1:0]  pop_dat,
   output logic [AW:0]   count
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          wr_en;
   logic          rd_en;

   assign wr_en   = push_vld && (count != (AW+1)'(DEPTH));
   assign rd_en   = pop_vld && pop_rdy;
   assign pop_vld = (count != '0);
   // Output forced to zero when empty so reset leaves out_data cleared without resetting the array.
   assign pop_dat = pop_vld ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= push_dat;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/wfm_capture.sv
// Triggered waveform recorder (optional header word under CAPTURE_HEADER_EN): PRE_LEN pre-trigger + POST_LEN samples per record.
// Latency: first record word written at the trigger cycle, visible on out_* one cycle later.
// Backpressure: out_valid/out_ready; a trigger that would not fit a whole record is dropped and counted.
module wfm_capture
   import wfm_capture_pkg::*;
#(
   parameter int PRE_LEN    = 8,
   parameter int POST_LEN   = 24,
   parameter int FIFO_DEPTH = 256
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [SMP_W-1:0]  in_0,
   input  logic [SMP_W-1:0]  in_1,
   input  logic [SMP_W-1:0]  in_2,
   input  logic [SMP_W-1:0]  in_3,
   input  logic              tot_0,
   input  logic              tot_1,
   input  logic              tot_2,
   input  logic              tot_3,
   input  logic              fvalid_in,
   input  logic [BSUM_W-1:0] bsum_in,
   input  logic              arm,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_data,
   output logic              out_valid,
   output logic              out_hdr,
   output logic              out_last,
   output logic              busy,
   output logic [DROP_W-1:0] drop_cnt
);

`ifdef CAPTURE_HEADER_EN
   localparam int HDR_LEN = 1;
`else
   localparam int HDR_LEN = 0;
`endif
   localparam int REC_LEN = PRE_LEN + POST_LEN + HDR_LEN;
   localparam int DLY     = PRE_LEN + HDR_LEN;
   localparam int CW      = $clog2(REC_LEN + 1);
   localparam int AW      = $clog2(FIFO_DEPTH);

   state_t            state;
   logic [CW-1:0]     word_cnt;
   logic [TS_W-1:0]   ts;
   logic              tot_q;
   logic              any_tot;
   logic              trig;
   logic              room_ok;
   logic [LINE_W-1:0] line_in;
   logic [LINE_W-1:0] dly [DLY];
   logic [AW:0]       fifo_cnt;
   logic              push_vld;
   logic              push_hdr;
   logic              push_last;
   logic [WORD_W-1:0] push_data;
   logic [FIFO_W-1:0] fifo_dat;

   assign any_tot = fvalid_in & (tot_0 | tot_1 | tot_2 | tot_3);
   assign trig    = any_tot & ~tot_q & arm & (state == ST_IDLE);
   assign room_ok = ((AW+1)'(FIFO_DEPTH) - fifo_cnt) >= (AW+1)'(REC_LEN);
   assign line_in = pack_line({tot_3, tot_2, tot_1, tot_0}, in_0, in_1, in_2, in_3);
   assign busy    = (state == ST_CAPTURE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ts    <= '0;
         tot_q <= 1'b0;
         for (int i = 0; i < DLY; i++) dly[i] <= '0;
      end else begin
         ts     <= ts + 1'b1;
         tot_q  <= any_tot;
         dly[0] <= line_in;
         for (int i = 1; i < DLY; i++) dly[i] <= dly[i-1];
      end
   end

   // Whole-record admission is decided once at the trigger; pops during the record only add space.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         word_cnt <= '0;
         drop_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (trig) begin
                  if (room_ok) begin
                     state    <= ST_CAPTURE;
                     word_cnt <= CW'(1);
                  end else if (drop_cnt != '1) begin
                     drop_cnt <= drop_cnt + 1'b1;
                  end
               end
            end
            default: begin
               if (word_cnt == CW'(REC_LEN - 1)) begin
                  state    <= ST_IDLE;
                  word_cnt <= '0;
               end else begin
                  word_cnt <= word_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   always_comb begin
      push_vld  = 1'b0;
      push_hdr  = 1'b0;
      push_last = 1'b0;
      push_data = {4'b0, dly[DLY-1]};
      if (state == ST_IDLE) begin
         if (trig && room_ok) begin
            push_vld = 1'b1;
`ifdef CAPTURE_HEADER_EN
            push_hdr  = 1'b1;
            push_data = {bsum_in, ts};
`endif
         end
      end else begin
         push_vld  = 1'b1;
         push_last = (word_cnt == CW'(REC_LEN - 1));
      end
   end

   capture_fifo #(
      .W     (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .push_vld (push_vld),
      .push_dat ({push_hdr, push_last, push_data}),
      .pop_vld  (out_valid),
      .pop_rdy  (out_ready),
      .pop_dat  (fifo_dat),
      .count    (fifo_cnt)
   );

   assign out_last = fifo_dat[WORD_W];
   assign out_data = fifo_dat[WORD_W-1:0];
`ifdef CAPTURE_HEADER_EN
   assign out_hdr  = fifo_dat[WORD_W+1];
`else
   logic unused_bits;
   assign out_hdr     = 1'b0;
   assign unused_bits = ^{bsum_in, ts, fifo_dat[WORD_W+1]};
`endif

endmodule

// File: doc/wfm_capture.md
WFM_CAPTURE -- requirements
Module: wfm_capture

Interface
REQ-001 SHALL have parameter PRE_LEN, default 8, meaning pre-trigger cycles per record (>=1).
REQ-002 SHALL have parameter POST_LEN, default 24, meaning cycles per record from the trigger cycle onward (>=1).
REQ-003 SHALL have parameter FIFO_DEPTH, default 256, meaning output FIFO depth in words (power of 2, >= REC_LEN).
REQ-004 SHALL have ports: clk in 1, sole clock; reset_n in 1, reset, asynchronous and active-low.
REQ-005 SHALL have ports in_0..in_3 in 14 each, the four delayed waveform samples from the FIR trigger stage (offset binary).
REQ-006 SHALL have ports tot_0..tot_3 in 1 each, time-over-threshold bits; fvalid_in in 1, filter output valid; bsum_in in 18, baseline sum.
REQ-007 SHALL have ports arm in 1, which enables new triggers, and out_ready in 1, the consumer ready signal.
REQ-008 SHALL have ports out_data out 64, out_valid out 1, out_hdr out 1, out_last out 1, busy out 1, drop_cnt out 16.

Function
REQ-009 REC_LEN SHALL equal PRE_LEN+POST_LEN, plus 1 when CAPTURE_HEADER_EN is defined.
REQ-010 The trigger SHALL be a rising edge of any_tot = fvalid_in & (tot_0|tot_1|tot_2|tot_3) versus its registered previous value, accepted only in IDLE with arm=1.
REQ-011 The input word {tot_3..tot_0, in_3..in_0} (60 bits) SHALL pass through a delay line of D = PRE_LEN (+1 when the header is enabled) cycles.
REQ-012 The FSM SHALL have states IDLE and CAPTURE: trigger at cycle t moves to CAPTURE; a word counter runs 0..REC_LEN-1; the last word returns to IDLE.
REQ-013 Over cycles t..t+REC_LEN-1, the delayed word SHALL be written per cycle, covering input cycles t-PRE_LEN .. t+POST_LEN-1; out_data = {4'b0, tot[3:0], in_3, in_2, in_1, in_0}.
REQ-014 out_last SHALL be 1 on the final word of a record and 0 otherwise.
REQ-015 Triggers during CAPTURE SHALL be ignored without counting; a tot held high over the end of a record SHALL NOT retrigger until it falls and rises again.
REQ-016 At the trigger cycle, if FIFO free space < REC_LEN, the record SHALL be dropped, drop_cnt incremented (saturating at 0xFFFF) and the FSM SHALL stay IDLE; a partial record SHALL never be written.
REQ-017 The FIFO SHALL be show-ahead: out_valid=1 whenever non-empty, and the word SHALL be popped on out_valid & out_ready; a simultaneous push and pop SHALL leave the count unchanged.
REQ-018 A word pushed into an empty FIFO SHALL appear on out_* in the next cycle.
REQ-019 busy SHALL be 1 in CAPTURE; arm deassertion mid-record SHALL NOT abort the record.
REQ-020 A 46-bit free-running timestamp SHALL increment every cycle and wrap to 0.

Reset
REQ-021 reset_n=0 SHALL asynchronously force IDLE, clear the delay line, timestamp, edge register, drop_cnt and FIFO pointers, and drive out_valid=0, out_hdr=0, out_last=0, busy=0, out_data=0.
REQ-022 Reset mid-record SHALL discard the FIFO contents and the partial record.

Configuration
REQ-023 Macro CAPTURE_HEADER_EN defined: the first record word SHALL be a header with out_hdr=1 and out_data = {bsum_in[17:0], timestamp[45:0]} sampled at trigger cycle t.
REQ-024 Macro CAPTURE_HEADER_EN undefined: there SHALL be no header word, out_hdr SHALL be constant 0, and D=PRE_LEN.

Structure
REQ-025 A shared package SHALL hold the FSM state enum, the record word field offsets, and the timestamp and drop counter widths.
REQ-026 A sub-module capture_fifo (66 bits: data, hdr, last; show-ahead, with a count output) SHALL be instantiated once.

Verification (header enabled, PRE_LEN=8, POST_LEN=24, REC_LEN=33)
REQ-027 in_0 = cycle index, tot_0 rises at cycle 100 with arm=1, out_ready=1 -> header has ts=100, followed by 32 words with in_0 = 92..123; out_last is set on the word with in_0=123.
REQ-028 tot_0 pulses at cycles 100 and 110 -> one record only, drop_cnt=0.
REQ-029 out_ready=0 and triggers every 40 cycles -> 7 records stored (231 words), the 8th trigger is dropped with drop_cnt=1, and no partial record appears.
REQ-030 fvalid_in=0 while tot_1=1, then fvalid_in rises -> trigger occurs at the fvalid_in rise cycle.
REQ-031 reset_n pulsed low at word 10 of a record -> outputs return to their reset values immediately, the FIFO is empty, and the next trigger yields a complete record.
REQ-032 With the header disabled, tot_2 rises at cycle 50 -> 32 words with in_0 = 42..73 and out_hdr always 0.
